// File: rtl/mc_bus_pkg.sv
// mc_bus_pkg: shared widths, register addresses and STATUS bit positions for the MCU bus controller
package mc_bus_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADD_WIDTH = 6;
  localparam int DEF_SYNC_STAGES = 2;
  localparam logic [7:0] ADR_FIFO = 8'h00;
  localparam logic [7:0] ADR_STATUS = 8'h18;
  localparam logic [7:0] ADR_CFG0 = 8'h19;
  localparam logic [7:0] ADR_CFG1 = 8'h1A;
  localparam logic [7:0] ADR_IRQMASK = 8'h1B;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF = 2;
  localparam int ST_UNF = 3;
endpackage

// File: rtl/mc_bus_if.sv
// mc_bus_if: MCU pin bundle; slave is the controller side, master the MCU side
interface mc_bus_if import mc_bus_pkg::*; #(
  parameter int DW = DEF_DATA_WIDTH,
  parameter int AW = DEF_ADD_WIDTH
);
  logic mc_ce;
  logic mc_we;
  logic mc_oe;
  logic [AW-1:0] mc_add;
  logic [DW-1:0] mc_din;
  logic [DW-1:0] mc_dout;
  logic mc_doe;
  modport slave (input mc_ce, mc_we, mc_oe, mc_add, mc_din, output mc_dout, mc_doe);
  modport master (output mc_ce, mc_we, mc_oe, mc_add, mc_din, input mc_dout, mc_doe);
endinterface

// File: rtl/mc_strobe_sync.sv
// mc_strobe_sync: synchronizes an active-low strobe (reset to idle-high) and pulses once per falling edge
module mc_strobe_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe_n,
  output logic lvl,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic [STAGES-1:0] vld;
  logic armed;
  assign lvl = sync[STAGES-1];
  assign fall = armed & ~lvl;
  // armed only once a genuine high is seen after reset, so a strobe held low through reset is ignored
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= '1;
      vld <= '0;
      armed <= 1'b0;
    end else begin
      sync <= STAGES'({sync, strobe_n});
      vld <= STAGES'({vld, 1'b1});
      armed <= (vld[STAGES-1] & lvl) ? 1'b1 : fall ? 1'b0 : armed;
    end
endmodule

// File: rtl/mc_bus_ctrl.sv
// mc_bus_ctrl: async MCU bus to FIFO/register bridge with STATUS, CFG0/1, IRQMASK and a level interrupt
module mc_bus_ctrl import mc_bus_pkg::*; #(
  parameter int MC_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MC_ADD_WIDTH = DEF_ADD_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  mc_bus_if.slave mc,
  output logic out_wr_en,
  output logic [MC_DATA_WIDTH-1:0] out_wr_data,
  input  logic out_full,
  output logic in_rd_en,
  input  logic [MC_DATA_WIDTH-1:0] in_rd_data,
  input  logic in_empty,
  output logic [MC_DATA_WIDTH-1:0] cfg0,
  output logic [MC_DATA_WIDTH-1:0] cfg1,
  output logic irq0
);
  localparam int DW = MC_DATA_WIDTH;
  localparam int AW = MC_ADD_WIDTH;
  logic we_fall, oe_fall, oe_lvl, ce_lvl;
  logic we_lvl_unused, ce_fall_unused;
  logic wr_stb, rd_stb, push;
  logic at_fifo, at_stat, at_cfg0, at_cfg1, at_mask;
  logic ovf, unf;
  logic [DW-1:0] irqmask, status, rd_val;
  mc_strobe_sync #(.STAGES(SYNC_STAGES)) u_we (.clk(clk), .rst(rst), .strobe_n(mc.mc_we), .lvl(we_lvl_unused), .fall(we_fall));
  mc_strobe_sync #(.STAGES(SYNC_STAGES)) u_oe (.clk(clk), .rst(rst), .strobe_n(mc.mc_oe), .lvl(oe_lvl), .fall(oe_fall));
  mc_strobe_sync #(.STAGES(SYNC_STAGES)) u_ce (.clk(clk), .rst(rst), .strobe_n(mc.mc_ce), .lvl(ce_lvl), .fall(ce_fall_unused));
  assign at_fifo = mc.mc_add == AW'(ADR_FIFO);
  assign at_stat = mc.mc_add == AW'(ADR_STATUS);
  assign at_cfg0 = mc.mc_add == AW'(ADR_CFG0);
  assign at_cfg1 = mc.mc_add == AW'(ADR_CFG1);
  assign at_mask = mc.mc_add == AW'(ADR_IRQMASK);
  // a write strobe in the same cycle swallows the read
  assign wr_stb = we_fall & ~ce_lvl;
  assign rd_stb = oe_fall & ~ce_lvl & ~wr_stb;
  assign push = wr_stb & at_fifo & ~out_full;
  assign in_rd_en = rd_stb & at_fifo & ~in_empty;
  always_comb begin
    status = '0;
    status[ST_EMPTY] = in_empty;
    status[ST_FULL] = out_full;
    status[ST_OVF] = ovf;
    status[ST_UNF] = unf;
    rd_val = at_fifo ? (in_empty ? '0 : in_rd_data) :
             at_stat ? status :
             at_cfg0 ? cfg0 :
             at_cfg1 ? cfg1 :
             at_mask ? irqmask : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_wr_en <= 1'b0;
      out_wr_data <= '0;
      cfg0 <= '0;
      cfg1 <= '0;
      irqmask <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      irq0 <= 1'b0;
      mc.mc_dout <= '0;
      mc.mc_doe <= 1'b0;
    end else begin
      out_wr_en <= push;
      if (push) out_wr_data <= mc.mc_din;
      if (wr_stb & at_cfg0) cfg0 <= mc.mc_din;
      if (wr_stb & at_cfg1) cfg1 <= mc.mc_din;
      if (wr_stb & at_mask) irqmask <= mc.mc_din;
      ovf <= (ovf & ~(wr_stb & at_stat & mc.mc_din[ST_OVF])) | (wr_stb & at_fifo & out_full);
      unf <= (unf & ~(wr_stb & at_stat & mc.mc_din[ST_UNF])) | (rd_stb & at_fifo & in_empty);
      irq0 <= |(irqmask[3:0] & {unf, ovf, out_full, ~in_empty});
      if (rd_stb) mc.mc_dout <= rd_val;
      mc.mc_doe <= rd_stb | (mc.mc_doe & ~oe_lvl & ~ce_lvl);
    end
endmodule

// File: tb/tb_mc_bus_ctrl.sv
// tb_mc_bus_ctrl: directed vector table plus hand sequences for strobe collisions, irq and reset corners
module tb_mc_bus_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_bus_if #(.DW(16), .AW(6)) bus();
  logic out_wr_en, out_full, in_rd_en, in_empty, irq0;
  logic [15:0] out_wr_data, in_rd_data, cfg0, cfg1;

  mc_bus_ctrl #(.MC_DATA_WIDTH(16), .MC_ADD_WIDTH(6), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .mc(bus),
    .out_wr_en(out_wr_en), .out_wr_data(out_wr_data), .out_full(out_full),
    .in_rd_en(in_rd_en), .in_rd_data(in_rd_data), .in_empty(in_empty),
    .cfg0(cfg0), .cfg1(cfg1), .irq0(irq0)
  );

  int tests = 0;
  int fails = 0;
  int push_cnt = 0;
  int pop_cnt = 0;
  int dbl = 0;
  logic [15:0] last_push = '0;
  logic prev_wr = 1'b0;
  logic prev_rd = 1'b0;
  logic doe_seen = 1'b0;

  always @(negedge clk)
    if (!rst) begin
      if (out_wr_en) begin
        push_cnt++;
        last_push = out_wr_data;
        if (prev_wr) dbl++;
      end
      if (in_rd_en) begin
        pop_cnt++;
        if (prev_rd) dbl++;
      end
      if (bus.mc_doe) doe_seen = 1'b1;
      prev_wr = out_wr_en;
      prev_rd = in_rd_en;
    end

  typedef struct {
    logic wr;
    logic [5:0] add;
    logic [15:0] din;
    logic full;
    logic empty;
    logic [15:0] head;
    int hold;
    logic exp_push;
    logic exp_pop;
    logic [15:0] exp;
  } vec_t;
  vec_t v[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic access(input logic wr, input logic [5:0] a, input logic [15:0] d, input int hold);
    bus.mc_add = a;
    bus.mc_din = d;
    bus.mc_ce = 1'b0;
    if (wr) bus.mc_we = 1'b0;
    else bus.mc_oe = 1'b0;
    tick(hold);
    if (!wr) chk("doe_during_read", 32'(bus.mc_doe), 32'd1);
    bus.mc_we = 1'b1;
    bus.mc_oe = 1'b1;
    bus.mc_ce = 1'b1;
    tick(6);
    if (!wr) chk("doe_after_read", 32'(bus.mc_doe), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    v[0]  = '{1'b1, 6'h19, 16'h0003, 1'b0, 1'b1, 16'h0000, 6, 1'b0, 1'b0, 16'h0000};
    v[1]  = '{1'b1, 6'h1A, 16'h0003, 1'b0, 1'b1, 16'h0000, 6, 1'b0, 1'b0, 16'h0000};
    v[2]  = '{1'b0, 6'h19, 16'h0000, 1'b0, 1'b1, 16'h0000, 6, 1'b0, 1'b0, 16'h0003};
    v[3]  = '{1'b0, 6'h1A, 16'h0000, 1'b0, 1'b1, 16'h0000, 6, 1'b0, 1'b0, 16'h0003};
    v[4]  = '{1'b1, 6'h00, 16'h0055, 1'b0, 1'b1, 16'h0000, 6, 1'b1, 1'b0, 16'h0055};
    v[5]  = '{1'b1, 6'h00, 16'h0020, 1'b0, 1'b1, 16'h0000, 6, 1'b1, 1'b0, 16'h0020};
    v[6]  = '{1'b1, 6'h00, 16'h0202, 1'b0, 1'b1, 16'h0000, 6, 1'b1, 1'b0, 16'h0202};
    v[7]  = '{1'b1, 6'h00, 16'h0303, 1'b0, 1'b1, 16'h0000, 6, 1'b1, 1'b0, 16'h0303};
    v[8]  = '{1'b1, 6'h00, 16'h1111, 1'b1, 1'b1, 16'h0000, 6, 1'b0, 1'b0, 16'h0000};
    v[9]  = '{1'b0, 6'h18, 16'h0000, 1'b1, 1'b1, 16'h0000, 6, 1'b0, 1'b0, 16'h0007};
    v[10] = '{1'b1, 6'h18, 16'h0004, 1'b0, 1'b1, 16'h0000, 6, 1'b0, 1'b0, 16'h0000};
    v[11] = '{1'b0, 6'h18, 16'h0000, 1'b0, 1'b1, 16'h0000, 6, 1'b0, 1'b0, 16'h0001};
    v[12] = '{1'b0, 6'h00, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 12, 1'b0, 1'b1, 16'hBEEF};
    v[13] = '{1'b0, 6'h00, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 6, 1'b0, 1'b0, 16'h0000};
    v[14] = '{1'b0, 6'h18, 16'h0000, 1'b0, 1'b1, 16'h0000, 6, 1'b0, 1'b0, 16'h0009};
    v[15] = '{1'b1, 6'h18, 16'h0008, 1'b0, 1'b1, 16'h0000, 6, 1'b0, 1'b0, 16'h0000};
    v[16] = '{1'b0, 6'h18, 16'h0000, 1'b0, 1'b0, 16'h1234, 6, 1'b0, 1'b0, 16'h0000};
    v[17] = '{1'b1, 6'h1B, 16'h00A5, 1'b0, 1'b1, 16'h0000, 6, 1'b0, 1'b0, 16'h0000};
    v[18] = '{1'b0, 6'h1B, 16'h0000, 1'b0, 1'b1, 16'h0000, 6, 1'b0, 1'b0, 16'h00A5};
    v[19] = '{1'b1, 6'h05, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 6, 1'b0, 1'b0, 16'h0000};
    v[20] = '{1'b0, 6'h05, 16'h0000, 1'b0, 1'b1, 16'h0000, 6, 1'b0, 1'b0, 16'h0000};

    bus.mc_ce = 1'b1;
    bus.mc_we = 1'b1;
    bus.mc_oe = 1'b1;
    bus.mc_add = '0;
    bus.mc_din = '0;
    out_full = 1'b0;
    in_empty = 1'b1;
    in_rd_data = '0;
    tick(3);
    chk("rst_dout", 32'(bus.mc_dout), 32'd0);
    chk("rst_doe", 32'(bus.mc_doe), 32'd0);
    chk("rst_wr_en", 32'(out_wr_en), 32'd0);
    chk("rst_rd_en", 32'(in_rd_en), 32'd0);
    chk("rst_wr_data", 32'(out_wr_data), 32'd0);
    chk("rst_cfg0", 32'(cfg0), 32'd0);
    chk("rst_cfg1", 32'(cfg1), 32'd0);
    chk("rst_irq0", 32'(irq0), 32'd0);
    rst = 1'b0;
    tick(4);

    for (int i = 0; i < 21; i++) begin
      int p0, r0;
      p0 = push_cnt;
      r0 = pop_cnt;
      out_full = v[i].full;
      in_empty = v[i].empty;
      in_rd_data = v[i].head;
      access(v[i].wr, v[i].add, v[i].din, v[i].hold);
      chk($sformatf("v%0d_push_count", i), 32'(push_cnt - p0), 32'(v[i].exp_push));
      chk($sformatf("v%0d_pop_count", i), 32'(pop_cnt - r0), 32'(v[i].exp_pop));
      if (v[i].wr && v[i].exp_push) chk($sformatf("v%0d_push_data", i), 32'(last_push), 32'(v[i].exp));
      if (!v[i].wr) chk($sformatf("v%0d_dout", i), 32'(bus.mc_dout), 32'(v[i].exp));
    end
    chk("cfg0_value", 32'(cfg0), 32'h0003);
    chk("cfg1_value", 32'(cfg1), 32'h0003);

    out_full = 1'b0;
    in_empty = 1'b1;
    access(1'b1, 6'h1B, 16'h0001, 6);
    chk("irq_masked_idle", 32'(irq0), 32'd0);
    in_empty = 1'b0;
    @(negedge clk);
    chk("irq_before_latency", 32'(irq0), 32'd0);
    @(negedge clk);
    chk("irq_rise", 32'(irq0), 32'd1);
    access(1'b1, 6'h1B, 16'h0000, 6);
    chk("irq_mask_clear", 32'(irq0), 32'd0);

    begin
      int p0, r0;
      p0 = push_cnt;
      r0 = pop_cnt;
      in_empty = 1'b0;
      in_rd_data = 16'hCAFE;
      doe_seen = 1'b0;
      bus.mc_add = 6'h1A;
      bus.mc_din = 16'h1234;
      bus.mc_ce = 1'b0;
      bus.mc_we = 1'b0;
      bus.mc_oe = 1'b0;
      tick(8);
      chk("collide_no_doe", 32'(doe_seen), 32'd0);
      chk("collide_cfg1", 32'(cfg1), 32'h1234);
      chk("collide_dout_kept", 32'(bus.mc_dout), 32'h0000);
      bus.mc_we = 1'b1;
      bus.mc_oe = 1'b1;
      tick(4);
      bus.mc_oe = 1'b0;
      tick(6);
      chk("reread_doe", 32'(bus.mc_doe), 32'd1);
      chk("reread_dout", 32'(bus.mc_dout), 32'h1234);
      chk("collide_push", 32'(push_cnt - p0), 32'd0);
      chk("collide_pop", 32'(pop_cnt - r0), 32'd0);
      bus.mc_oe = 1'b1;
      bus.mc_ce = 1'b1;
      tick(6);
    end

    begin
      int p0;
      p0 = push_cnt;
      in_empty = 1'b1;
      rst = 1'b1;
      tick(2);
      bus.mc_add = 6'h19;
      bus.mc_din = 16'h7777;
      bus.mc_ce = 1'b0;
      bus.mc_we = 1'b0;
      tick(1);
      rst = 1'b0;
      tick(10);
      chk("held_we_no_cfg0", 32'(cfg0), 32'd0);
      chk("held_we_no_push", 32'(push_cnt - p0), 32'd0);
      bus.mc_we = 1'b1;
      tick(4);
      bus.mc_we = 1'b0;
      tick(6);
      chk("next_we_cfg0", 32'(cfg0), 32'h7777);
      bus.mc_we = 1'b1;
      bus.mc_ce = 1'b1;
      tick(6);
    end

    chk("single_cycle_pulses", 32'(dbl), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mc_bus_ctrl.md
MC_BUS_CTRL -- requirements
Module: mc_bus_ctrl

Interface
REQ-001 Parameter MC_DATA_WIDTH, default 16, MCU data bus width.
REQ-002 Parameter MC_ADD_WIDTH, default 6, MCU address bus width.
REQ-003 Parameter SYNC_STAGES, default 2, synchronizer depth for MCU strobes.
REQ-004 clock  in  1  single system clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 mc_ce, mc_we, mc_oe  in  1 each  MCU chip enable, write strobe and output enable; all active-low and asynchronous to clock.
REQ-007 mc_add  in  MC_ADD_WIDTH  MCU address; stable throughout a strobe.
REQ-008 mc_din  in  MC_DATA_WIDTH  MCU write data; stable throughout mc_we low.
REQ-009 mc_dout  out  MC_DATA_WIDTH  read data toward the pad tristate.
REQ-010 mc_doe  out  1  pad tristate enable; high drives mc_dout.
REQ-011 out_wr_en  out  1  one-cycle push into the outbound command FIFO.
REQ-012 out_wr_data  out  MC_DATA_WIDTH  push data.
REQ-013 out_full  in  1  outbound FIFO full.
REQ-014 in_rd_en  out  1  one-cycle pop from the inbound result FIFO (first-word-fall-through).
REQ-015 in_rd_data  in  MC_DATA_WIDTH  inbound head word; valid when in_empty is low.
REQ-016 in_empty  in  1  inbound FIFO empty.
REQ-017 cfg0, cfg1  out  MC_DATA_WIDTH each  configuration registers.
REQ-018 irq0  out  1  interrupt, level, active-high.

Function
REQ-019 mc_we, mc_oe and mc_ce are each synchronized through SYNC_STAGES flops; mc_add and mc_din are sampled unsynchronized only on a strobe cycle.
REQ-020 Write strobe: one-cycle pulse on the first cycle the synchronized we is low after having been high, qualified by synchronized ce low.
REQ-021 Read strobe: same rule applied to synchronized oe.
REQ-022 Address map: 0x00 FIFO port; 0x18 STATUS; 0x19 CFG0; 0x1A CFG1; 0x1B IRQMASK; all other addresses read 0, writes are ignored.
REQ-023 Write to 0x00 with out_full low: out_wr_en=1 for exactly one cycle, the cycle after the write strobe, with out_wr_data=mc_din.
REQ-024 Write to 0x00 with out_full high: no push; STATUS.ovf (bit 2) is set sticky.
REQ-025 Write to 0x19, 0x1A or 0x1B: the register updates on the cycle after the write strobe; the cfg outputs reflect the new value from that cycle.
REQ-026 Write to 0x18: each 1 bit in mc_din[3:2] clears the matching sticky bit (write-1-to-clear).
REQ-027 STATUS bits: [0] in_empty, [1] out_full, [2] ovf, [3] unf, [15:4] zero.
REQ-028 Read strobe: mc_dout is latched from the addressed source on the strobe cycle and held until the next read strobe.
REQ-029 Read 0x00 with in_empty low: latch in_rd_data and pulse in_rd_en for exactly that one cycle.
REQ-030 Read 0x00 with in_empty high: latch 0x0000, no pop; STATUS.unf (bit 3) is set sticky.
REQ-031 mc_doe is high from the cycle after the read strobe until the synchronized oe is high or the synchronized ce is high.
REQ-032 Simultaneous write and read strobe: the write is performed and the read is discarded (no pop, mc_doe stays low); the read executes only on the next oe falling edge.
REQ-033 Holding a strobe low causes exactly one access; there are no repeats.
REQ-034 irq0 = |(IRQMASK[3:0] & {unf, ovf, out_full, ~in_empty}), registered, one-cycle latency.
REQ-035 Worst-case latency from pin edge to FIFO action is SYNC_STAGES+2 clock cycles.

Reset
REQ-036 While reset is high: all synchronizer flops reset to 1 (strobes deasserted); mc_dout=0, mc_doe=0, out_wr_en=0, in_rd_en=0, out_wr_data=0, cfg0=cfg1=IRQMASK=0, sticky bits=0, irq0=0.
REQ-037 A strobe already low when reset deasserts produces no access; the next falling edge is required.
REQ-038 Reset asserted mid-access aborts any pending push or pop; no partial pulse appears after reset releases.

Structure
REQ-039 Package mc_bus_pkg holds the address constants, the STATUS bit indices and the default widths.
REQ-040 Sub-module mc_strobe_sync (synchronizer, reset-to-1, and falling-edge pulse) is instantiated once per strobe.

Verification
REQ-041 Write 0x0003 to 0x19, then 0x0003 to 0x1A -> cfg0=0x0003 and cfg1=0x0003; no out_wr_en.
REQ-042 Write 0x0055, 0x0020, 0x0202 and 0x0303 to 0x00 with out_full=0 -> four single-cycle out_wr_en pulses carrying those values, in order.
REQ-043 Write to 0x00 with out_full=1 -> no push; a read of 0x18 returns bit2=1; writing 0x0004 to 0x18 clears it.
REQ-044 Inbound head 0xBEEF, read 0x00 with oe held low for 12 cycles -> mc_dout=0xBEEF, exactly one in_rd_en pulse, mc_doe high until oe rises; a read while empty returns 0x0000 and sets unf.
REQ-045 IRQMASK=0x0001 and in_empty falls -> irq0 rises one cycle later; clearing the mask drops irq0.
REQ-046 mc_we falls 1 cycle before reset deasserts -> no push or register write until the next we falling edge.
